mmu_job_arbiter: RTL

MMU_JOB_ARBITER -- requirements
Module: mmu_job_arbiter

---
 rtl/mmu_job_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mmu_job_arbiter.sv
// Round-robin arbiter that grants one of two requesters exclusive use of a 2x2 matmul unit.
// A job loads 8 operand bytes, runs the MMU for COMPUTE_CYCLES, then drains 8 result bytes.
module mmu_job_arbiter #(
  parameter int COMPUTE_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [7:0]  in_data0,
  input  logic [7:0]  in_data1,
  input  logic [1:0]  in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [2:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mmu_en,
  output logic [2:0]  mmu_cycle,
  input  logic [63:0] res_in,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam logic [2:0] LAST_CYCLE = 3'(COMPUTE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_owner_q, last_owner_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  cycle_q, cycle_d;
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic [63:0] res_q, res_d;

  logic owner;
  logic winner;
  logic owner_valid;

  assign owner       = gnt_q[1];
  assign owner_valid = in_valid[owner];
  // On a tie the requester that did not finish the previous job wins.
  assign winner      = (req == 2'b11) ? ~last_owner_q : req[1];

  assign gnt       = gnt_q;
  assign state_out = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      last_owner_q <= 1'b1;
      byte_cnt_q   <= 3'd0;
      cycle_q      <= 3'd0;
      out_cnt_q    <= 3'd0;
      res_q        <= 64'd0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_owner_q <= last_owner_d;
      byte_cnt_q   <= byte_cnt_d;
      cycle_q      <= cycle_d;
      out_cnt_q    <= out_cnt_d;
      res_q        <= res_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_owner_d = last_owner_q;
    byte_cnt_d   = byte_cnt_q;
    cycle_d      = cycle_q;
    out_cnt_d    = out_cnt_q;
    res_d        = res_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = LOAD;
          gnt_d   = winner ? 2'b10 : 2'b01;
        end
      end
      LOAD: begin
        if (owner_valid) begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) begin
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        if (cycle_q == LAST_CYCLE) begin
          cycle_d = 3'd0;
          res_d   = res_in;
          state_d = DRAIN;
        end else begin
          cycle_d = cycle_q + 3'd1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          out_cnt_d = out_cnt_q + 3'd1;
          if (out_cnt_q == 3'd7) begin
            state_d      = IDLE;
            gnt_d        = 2'b00;
            last_owner_d = owner;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 3'd0;
    mem_wdata = 8'd0;
    mmu_en    = 1'b0;
    mmu_cycle = 3'd0;
    out_valid = 1'b0;
    out_data  = 8'd0;
    out_last  = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (owner_valid) begin
          mem_we    = 1'b1;
          mem_addr  = byte_cnt_q;
          mem_wdata = owner ? in_data1 : in_data0;
        end
      end
      COMPUTE: begin
        mmu_en    = 1'b1;
        mmu_cycle = cycle_q;
      end
      DRAIN: begin
        // Byte 0 is the top byte of c00, byte 7 the bottom byte of c11.
        out_valid = 1'b1;
        out_data  = res_q[{~out_cnt_q, 3'b000} +: 8];
        out_last  = (out_cnt_q == 3'd7);
      end
      default: begin
      end
    endcase
  end

endmodule
